// File: rtl/write_back_unit_if.sv
// rtl/write_back_unit_if.sv - write-back stage bus: retire handshake, memory response, regfile port (optional forwarding under WB_FWD_EN)
interface write_back_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_wen;
    logic                  in_is_load;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]     in_alu;
    logic [OFF_W-1:0]      in_off;
    logic [1:0]            in_size;
    logic                  in_unsigned;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  write_en;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;
    logic                  busy;
`ifdef WB_FWD_EN
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_reg;
    logic [DATA_W-1:0]     fwd_data;
    logic                  fwd_pend;
    logic [REG_ADDR_W-1:0] fwd_pend_reg;
`endif

`ifdef WB_FWD_EN
    modport slave (
        input  in_valid, in_wen, in_is_load, in_rd, in_alu, in_off, in_size, in_unsigned,
        input  mem_rvalid, mem_rdata,
        output in_ready, write_en, write_reg, write_data, busy,
        output fwd_valid, fwd_reg, fwd_data, fwd_pend, fwd_pend_reg
    );
    modport master (
        output in_valid, in_wen, in_is_load, in_rd, in_alu, in_off, in_size, in_unsigned,
        output mem_rvalid, mem_rdata,
        input  in_ready, write_en, write_reg, write_data, busy,
        input  fwd_valid, fwd_reg, fwd_data, fwd_pend, fwd_pend_reg
    );
`else
    modport slave (
        input  in_valid, in_wen, in_is_load, in_rd, in_alu, in_off, in_size, in_unsigned,
        input  mem_rvalid, mem_rdata,
        output in_ready, write_en, write_reg, write_data, busy
    );
    modport master (
        output in_valid, in_wen, in_is_load, in_rd, in_alu, in_off, in_size, in_unsigned,
        output mem_rvalid, mem_rdata,
        input  in_ready, write_en, write_reg, write_data, busy
    );
`endif
endinterface

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - registered write-back stage with load alignment/extension; optional forwarding ports under WB_FWD_EN
module write_back_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    write_back_unit_if.slave    bus
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  write_en_q, write_en_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;

    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_W-1:0]     load_ext;

    // Lane pick and extension; memory data is big-endian, so lane 0 sits in the top bits
    always_comb begin
        lane_b = 8'h00;
        lane_h = 16'h0000;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (off_q == OFF_W'(k)) lane_b = bus.mem_rdata[DATA_W-1-8*k -: 8];
        end
        for (int k = 0; k < DATA_W / 16; k++) begin
            if (off_q[OFF_W-1:1] == (OFF_W-1)'(k)) lane_h = bus.mem_rdata[DATA_W-1-16*k -: 16];
        end
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane_b}
                                      : {{(DATA_W-8){lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane_h}
                                      : {{(DATA_W-16){lane_h[15]}}, lane_h};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Next-state: ALU results retire straight through, loads park in WAIT_MEM until the response
    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        rd_d         = rd_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        write_en_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!bus.in_is_load) begin
                        write_en_d = bus.in_wen;
                        if (bus.in_wen) begin
                            write_reg_d  = bus.in_rd;
                            write_data_d = bus.in_alu;
                        end
                    end else begin
                        wen_d   = bus.in_wen;
                        rd_d    = bus.in_rd;
                        off_d   = bus.in_off;
                        size_d  = bus.in_size;
                        uns_d   = bus.in_unsigned;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    write_en_d = wen_q;
                    if (wen_q) begin
                        write_reg_d  = rd_q;
                        write_data_d = load_ext;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any outstanding load
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            rd_q         <= '0;
            off_q        <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            rd_q         <= rd_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_en_q   <= write_en_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == WAIT_MEM);
    assign bus.write_en   = write_en_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

`ifdef WB_FWD_EN
    assign bus.fwd_valid    = write_en_q;
    assign bus.fwd_reg      = write_reg_q;
    assign bus.fwd_data     = write_data_q;
    assign bus.fwd_pend     = (state_q == WAIT_MEM);
    assign bus.fwd_pend_reg = (state_q == WAIT_MEM) ? rd_q : '0;
`endif
endmodule
